uart_rx: RTL and testbench

- 8N1 UART receive stage, directly downstream of the baud generator.
- Consumes the 16x-oversampled receive_baud enable pulse.
- Synchronises the serial RX line, validates the start bit, and samples each bit at mid-bit.
- Presents the received byte to the SPART/bus interface with a data-available flag, plus framing and overrun status.

---
 rtl/uart_rx.sv | 157 +++++++++++++++
 tb/tb_uart_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchroniser, start-bit validation and
// mid-bit sampling on an oversampled baud tick, with sticky framing/overrun status.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_baud,
  input  logic                 rxd,
  input  logic                 clr_rda,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rda_q, rda_d;
  logic                 framing_err_q, framing_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rxd_meta_q, rxd_sync_q;
  logic                 rxd_s;

  assign rxd_s       = rxd_sync_q;
  assign rx_data     = rx_data_q;
  assign rda         = rda_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  // Next-state, counters, shifter and status; clr_rda acts on every clk, the rest only on ticks.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bitcnt_d      = bitcnt_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    framing_err_d = framing_err_q;
    rda_d         = clr_rda ? 1'b0 : rda_q;
    overrun_d     = clr_rda ? 1'b0 : overrun_q;

    if (rx_baud) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d = START;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = IDLE;
          end
        end
        START: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_MID) begin
            cnt_d    = {CNT_W{1'b0}};
            bitcnt_d = {BIT_W{1'b0}};
            state_d  = rxd_s ? IDLE : DATA;
          end else begin
            state_d = START;
          end
        end
        DATA: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            shift_d  = {rxd_s, shift_q[DATA_BITS-1:1]};
            cnt_d    = {CNT_W{1'b0}};
            bitcnt_d = bitcnt_q + BIT_W'(1);
            state_d  = (bitcnt_q == BIT_LAST) ? STOP : DATA;
          end else begin
            state_d = DATA;
          end
        end
        STOP: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            cnt_d = {CNT_W{1'b0}};
            if (rxd_s) begin
              // A same-cycle clr_rda means the bus consumed the old byte, so no overrun.
              rx_data_d     = shift_q;
              rda_d         = 1'b1;
              framing_err_d = 1'b0;
              overrun_d     = (rda_q && !clr_rda) ? 1'b1 : overrun_d;
              state_d       = IDLE;
            end else begin
              framing_err_d = 1'b1;
              state_d       = WAIT_HIGH;
            end
          end else begin
            state_d = STOP;
          end
        end
        WAIT_HIGH: begin
          state_d = rxd_s ? IDLE : WAIT_HIGH;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Receiver state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      bitcnt_q      <= {BIT_W{1'b0}};
      shift_q       <= {DATA_BITS{1'b0}};
      rx_data_q     <= {DATA_BITS{1'b0}};
      rda_q         <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rda_q         <= rda_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level reference model checked every cycle,
// plus literal expectations after each scenario.
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rx_baud;
  logic       rxd;
  logic       clr_rda;
  logic [7:0] rx_data;
  logic       rda;
  logic       framing_err;
  logic       overrun;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_baud     (rx_baud),
    .rxd         (rxd),
    .clr_rda     (clr_rda),
    .rx_data     (rx_data),
    .rda         (rda),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  // A frame's stop bit is sampled this many clks after the tick preceding its start edge.
  localparam int STOP_LAT = 612;

  typedef struct {
    int         cyc;
    bit         is_clr;
    bit         stop;
    logic [7:0] data;
  } ev_t;

  ev_t        evq[$];
  int         cyc = 0;
  int         clr_cyc = -100;
  int         n_cmp = 0;
  int         n_err = 0;
  int         div = 0;
  logic [7:0] m_data;
  logic       m_rda, m_fe, m_ov;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // rx_baud: one clk high every 4 clks
  initial begin
    rx_baud = 1'b0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      rx_baud = (div == 3);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: outputs change only at frame completions, clr pulses and reset.
  initial begin
    bit clr_now, frm_now, frm_stop;
    logic [7:0] frm_data;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_data = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        evq.delete();
      end else begin
        clr_now = 1'b0; frm_now = 1'b0; frm_stop = 1'b0; frm_data = 8'h00;
        for (int i = evq.size() - 1; i >= 0; i--) begin
          if (evq[i].cyc <= cyc) begin
            if (evq[i].is_clr) clr_now = 1'b1;
            else begin frm_now = 1'b1; frm_stop = evq[i].stop; frm_data = evq[i].data; end
            evq.delete(i);
          end
        end
        if (frm_now && frm_stop) begin
          m_ov   = clr_now ? 1'b0 : (m_ov | m_rda);
          m_rda  = 1'b1;
          m_data = frm_data;
          m_fe   = 1'b0;
        end else begin
          if (frm_now) m_fe = 1'b1;
          if (clr_now) begin m_rda = 1'b0; m_ov = 1'b0; end
        end
      end
      check("model_rx_data", rx_data, m_data);
      check("model_rda", rda, m_rda);
      check("model_framing_err", framing_err, m_fe);
      check("model_overrun", overrun, m_ov);
    end
  end

  // One negedge step, issuing a scheduled clr_rda pulse.
  task automatic step();
    @(negedge clk);
    if (cyc == clr_cyc) begin
      clr_rda = 1'b1;
      evq.push_back('{cyc: cyc + 1, is_clr: 1'b1, stop: 1'b0, data: 8'h00});
    end else begin
      clr_rda = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) step();
  endtask

  task automatic pulse_clr();
    clr_cyc = cyc + 1;
    step();
    step();
  endtask

  task automatic send_frame(input logic [7:0] data, input bit stop, input bit clr_at_end);
    logic [9:0] bits;
    int k;
    bits = {stop, data, 1'b0};
    do @(posedge clk); while (!rx_baud);
    step();
    k = cyc;
    evq.push_back('{cyc: k + STOP_LAT, is_clr: 1'b0, stop: stop, data: data});
    if (clr_at_end) clr_cyc = k + STOP_LAT - 1;
    for (int j = 0; j < 10; j++) begin
      rxd = bits[j];
      repeat (64) step();
    end
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] d, input logic r,
                            input logic fe, input logic ov);
    check({tag, "_rx_data"}, rx_data, d);
    check({tag, "_rda"}, rda, r);
    check({tag, "_framing_err"}, framing_err, fe);
    check({tag, "_overrun"}, overrun, ov);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] part;
    rst_n = 1'b0; rxd = 1'b1; clr_rda = 1'b0;
    repeat (3) @(negedge clk);
    #1 expect_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2 rst_n = 1'b1;
    idle(16);

    send_frame(8'hA5, 1'b1, 1'b0);
    expect_out("a5", 8'hA5, 1'b1, 1'b0, 1'b0);

    pulse_clr();
    #1 expect_out("clr", 8'hA5, 1'b0, 1'b0, 1'b0);

    rxd = 1'b0;
    repeat (16) step();
    idle(96);
    #1 expect_out("glitch", 8'hA5, 1'b0, 1'b0, 1'b0);

    send_frame(8'h3C, 1'b0, 1'b0);
    expect_out("ferr", 8'hA5, 1'b0, 1'b1, 1'b0);
    repeat (160) step();
    #1 expect_out("break", 8'hA5, 1'b0, 1'b1, 1'b0);
    idle(32);
    send_frame(8'h81, 1'b1, 1'b0);
    expect_out("after_break", 8'h81, 1'b1, 1'b0, 1'b0);

    pulse_clr();
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    expect_out("overrun", 8'hC3, 1'b1, 1'b0, 1'b1);
    pulse_clr();
    #1 expect_out("clr_ovr", 8'hC3, 1'b0, 1'b0, 1'b0);

    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b1);
    clr_cyc = -100;
    expect_out("clr_same", 8'h55, 1'b1, 1'b0, 1'b0);

    // Partial frame 0x96 aborted by reset in the middle of data bit 4.
    part = 8'h96;
    do @(posedge clk); while (!rx_baud);
    step();
    rxd = 1'b0;
    repeat (64) step();
    for (int j = 0; j < 4; j++) begin
      rxd = part[j];
      repeat (64) step();
    end
    rxd = part[4];
    repeat (32) step();
    @(posedge clk); #2 rst_n = 1'b0; rxd = 1'b1;
    @(negedge clk); #1 expect_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    idle(200);
    #1 expect_out("post_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0);
    expect_out("7e", 8'h7E, 1'b1, 1'b0, 1'b0);

    idle(8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
